// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : des_pkg
//  Purpose  : DES geometry, key-shift schedule, FSM states and standard tables.
//  Revision : 1.0
// ============================================================================
package des_pkg;

  localparam int NUM_ROUNDS = 16;
  localparam int BLOCK_W    = 64;
  localparam int CD_W       = 56;
  localparam int SUBKEY_W   = 48;
  localparam int HALF_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Left-rotate amount of C and D before each round; totals 28 over 16 rounds.
  localparam logic [1:0] SHIFT [NUM_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // Tables list 1-based source positions with position 1 being the MSB.
  localparam byte unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam byte unsigned IPINV_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam byte unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam byte unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam byte unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam byte unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Indexed by {row, column} = {b6, b1, b5..b2} of each 6-bit group.
  localparam logic [3:0] SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

endpackage
`default_nettype wire

// File: rtl/encrypt_iterative_if.sv
`default_nettype none
// ============================================================================
//  Module   : encrypt_iterative_if
//  Purpose  : Start/result handshake of the iterative DES encryptor.
//  Revision : 1.0
// ============================================================================
interface encrypt_iterative_if;
  import des_pkg::*;

  logic               start;
  logic [BLOCK_W-1:0] message;
  logic [BLOCK_W-1:0] key;
  logic               busy;
  logic               done;
  logic [BLOCK_W-1:0] encryptmessage;

  modport master (output start, message, key, input busy, done, encryptmessage);
  modport slave  (input start, message, key, output busy, done, encryptmessage);
endinterface
`default_nettype wire

// File: rtl/dataip.sv
`default_nettype none
// ============================================================================
//  Module   : dataip
//  Purpose  : DES initial permutation (IP).
//  Revision : 1.0
// ============================================================================
module dataip
  import des_pkg::*;
(
  input  wire logic [BLOCK_W-1:0] din,
  output logic      [BLOCK_W-1:0] dout
);
  for (genvar i = 0; i < BLOCK_W; i++) begin : g_bit
    assign dout[BLOCK_W-1-i] = din[BLOCK_W-IP_T[i]];
  end
endmodule
`default_nettype wire

// File: rtl/des_round.sv
`default_nettype none
// ============================================================================
//  Module   : des_round
//  Purpose  : One combinational Feistel round with its key-schedule step.
//  Revision : 1.0
// ============================================================================
module des_round
  import des_pkg::*;
(
  input  wire logic [HALF_W-1:0] l,
  input  wire logic [HALF_W-1:0] r,
  input  wire logic [CD_W-1:0]   cd,
  input  wire logic [1:0]        shift,
  output logic      [HALF_W-1:0] l_next,
  output logic      [HALF_W-1:0] r_next,
  output logic      [CD_W-1:0]   cd_next
);
  logic [27:0]         w_c;
  logic [27:0]         w_d;
  logic [SUBKEY_W-1:0] w_subkey;
  logic [HALF_W-1:0]   w_f;

  assign w_c = cd[55:28];
  assign w_d = cd[27:0];

  // The schedule only ever asks for 1 or 2; anything else rotates by 2.
  assign cd_next = (shift == 2'd1) ?
                   {w_c[26:0], w_c[27], w_d[26:0], w_d[27]} :
                   {w_c[25:0], w_c[27:26], w_d[25:0], w_d[27:26]};

  pctwo u_pctwo (
    .cd     (cd_next),
    .subkey (w_subkey)
  );

  fencode u_fencode (
    .r      (r),
    .subkey (w_subkey),
    .f      (w_f)
  );

  assign l_next = r;
  assign r_next = l ^ w_f;
endmodule
`default_nettype wire

// File: rtl/fencode.sv
`default_nettype none
// ============================================================================
//  Module   : fencode
//  Purpose  : DES f-function: expand, key mix, S-box substitution, P permute.
//  Revision : 1.0
// ============================================================================
module fencode
  import des_pkg::*;
(
  input  wire logic [HALF_W-1:0]   r,
  input  wire logic [SUBKEY_W-1:0] subkey,
  output logic      [HALF_W-1:0]   f
);
  logic [SUBKEY_W-1:0] w_e;
  logic [SUBKEY_W-1:0] w_x;
  logic [HALF_W-1:0]   w_s;

  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_expand
    assign w_e[SUBKEY_W-1-i] = r[HALF_W-E_T[i]];
  end

  assign w_x = w_e ^ subkey;

  for (genvar j = 0; j < 8; j++) begin : g_sbox
    assign w_s[HALF_W-1-4*j -: 4] =
      SBOX[j][{w_x[47-6*j], w_x[42-6*j], w_x[46-6*j -: 4]}];
  end

  for (genvar i = 0; i < HALF_W; i++) begin : g_perm
    assign f[HALF_W-1-i] = w_s[HALF_W-P_T[i]];
  end
endmodule
`default_nettype wire

// File: rtl/ipinverse.sv
`default_nettype none
// ============================================================================
//  Module   : ipinverse
//  Purpose  : DES final permutation (IP^-1).
//  Revision : 1.0
// ============================================================================
module ipinverse
  import des_pkg::*;
(
  input  wire logic [BLOCK_W-1:0] din,
  output logic      [BLOCK_W-1:0] dout
);
  for (genvar i = 0; i < BLOCK_W; i++) begin : g_bit
    assign dout[BLOCK_W-1-i] = din[BLOCK_W-IPINV_T[i]];
  end
endmodule
`default_nettype wire

// File: rtl/pcone.sv
`default_nettype none
// ============================================================================
//  Module   : pcone
//  Purpose  : DES permuted choice 1; drops the eight key parity bits.
//  Revision : 1.0
// ============================================================================
module pcone
  import des_pkg::*;
(
  input  wire logic [BLOCK_W-1:0] key,
  output logic      [CD_W-1:0]    cd
);
  logic w_unused_parity;

  for (genvar i = 0; i < CD_W; i++) begin : g_bit
    assign cd[CD_W-1-i] = key[BLOCK_W-PC1_T[i]];
  end

  assign w_unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8], key[0]};
endmodule
`default_nettype wire

// File: rtl/pctwo.sv
`default_nettype none
// ============================================================================
//  Module   : pctwo
//  Purpose  : DES permuted choice 2; selects the 48-bit round subkey.
//  Revision : 1.0
// ============================================================================
module pctwo
  import des_pkg::*;
(
  input  wire logic [CD_W-1:0]     cd,
  output logic      [SUBKEY_W-1:0] subkey
);
  logic w_unused_dropped;

  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_bit
    assign subkey[SUBKEY_W-1-i] = cd[CD_W-PC2_T[i]];
  end

  // Positions 9, 18, 22, 25, 35, 38, 43 and 54 never reach a subkey.
  assign w_unused_dropped = ^{cd[47], cd[38], cd[34], cd[31],
                              cd[21], cd[18], cd[13], cd[2]};
endmodule
`default_nettype wire

// File: rtl/encrypt_iterative.sv
`default_nettype none
// ============================================================================
//  Module   : encrypt_iterative
//  Purpose  : DES encryptor running one Feistel round per clock (17-cycle latency).
//  Revision : 1.0
// ============================================================================
module encrypt_iterative
  import des_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  encrypt_iterative_if.slave bus
);
  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_rnd;
  logic [HALF_W-1:0]  r_l;
  logic [HALF_W-1:0]  r_r;
  logic [CD_W-1:0]    r_cd;
  logic               r_done;
  logic [BLOCK_W-1:0] r_ct;

  logic [BLOCK_W-1:0] w_ip;
  logic [CD_W-1:0]    w_cd_load;
  logic [1:0]         w_shift;
  logic [HALF_W-1:0]  w_l_next;
  logic [HALF_W-1:0]  w_r_next;
  logic [CD_W-1:0]    w_cd_next;
  logic [BLOCK_W-1:0] w_ct;
  logic               w_last;

  dataip u_dataip (
    .din  (bus.message),
    .dout (w_ip)
  );

  pcone u_pcone (
    .key (bus.key),
    .cd  (w_cd_load)
  );

  assign w_shift = SHIFT[r_rnd];

  des_round u_round (
    .l       (r_l),
    .r       (r_r),
    .cd      (r_cd),
    .shift   (w_shift),
    .l_next  (w_l_next),
    .r_next  (w_r_next),
    .cd_next (w_cd_next)
  );

  // Final swap: the preoutput block is R16 followed by L16.
  ipinverse u_ipinverse (
    .din  ({r_r, r_l}),
    .dout (w_ct)
  );

  assign w_last = (r_rnd == 4'(NUM_ROUNDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = ROUND;
      ROUND:   if (w_last) w_state_next = OUT;
      OUT:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rnd  <= '0;
      r_l    <= '0;
      r_r    <= '0;
      r_cd   <= '0;
      r_done <= 1'b0;
      r_ct   <= '0;
    end else begin
      r_done <= (r_state == OUT);
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_l   <= w_ip[63:32];
            r_r   <= w_ip[31:0];
            r_cd  <= w_cd_load;
            r_rnd <= '0;
          end
        end
        ROUND: begin
          r_l   <= w_l_next;
          r_r   <= w_r_next;
          r_cd  <= w_cd_next;
          r_rnd <= r_rnd + 4'd1;
        end
        OUT:     r_ct <= w_ct;
        default: ;
      endcase
    end
  end

  assign bus.busy           = (r_state != IDLE);
  assign bus.done           = r_done;
  assign bus.encryptmessage = r_ct;
endmodule
`default_nettype wire

// File: doc/encrypt_iterative.md
# encrypt_iterative

Iterative DES encryptor that processes one Feistel round per clock, so one round datapath replaces a 16-stage unrolled network. It accepts a 64-bit plaintext and 64-bit key on a start pulse and returns the 64-bit ciphertext 17 cycles later with a one-cycle done strobe. It is the transmit-side counterpart of the combinational `decrypt` block, and its output must decrypt back to the original plaintext under the same key. It reuses the existing DES primitives `dataip`, `pcone`, `pctwo`, `fencode` and `ipinverse`.

## Interface
- Parameters: none. DES geometry is fixed.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- message  in  64  plaintext, bit 63 = DES bit 1. Sampled on the accepting edge only.
- key  in  64  DES key including parity bits. Sampled on the accepting edge only.
- busy  out  1  high while a block is in flight (state ≠ IDLE).
- done  out  1  registered one-cycle strobe; encryptmessage is valid from this cycle on.
- encryptmessage  out  64  ciphertext register. Holds its value until the next completion.

## Operation
- FSM states:
  - IDLE: on start=1, load L/R ← halves of IP(message) (L = [63:32]). Load CD ← PC-1(key) (56 bits, C = [55:28]). Clear rnd. Go to ROUND.
  - ROUND: each cycle rotate C and D left by SHIFT[rnd]: 1 for rounds 1, 2, 9, 16; 2 otherwise.
    - K = PC-2(rotated CD). CD ← rotated CD.
    - L ← R; R ← L ^ f(R, K).
    - rnd increments. When rnd = 15, go to OUT.
  - OUT: encryptmessage ← IPinv({R, L}) (halves swapped). done ← 1. Go to IDLE.
- rnd is a 4-bit counter, 0..15; its value is used only inside ROUND.
- Key order is K1..K16, the forward schedule. The decryptor consumes the same keys as K16..K1.
- start in ROUND or OUT is ignored: no queuing, no effect on the in-flight block.
- message and key may change freely after the accepting edge.
- Cumulative rotation after 16 rounds is 28, so CD returns to PC-1(key). The bench checks this as an internal sanity assertion.

## Timing
- E0: accepting edge (start=1 in IDLE). Edges E1..E16 perform rounds 1..16. Edge E17 performs the OUT actions.
- busy is combinational from state. It is high from after E0 until E17.
- done is high for exactly the cycle between E17 and E18.
- Latency from start sample to done: 17 cycles.
- The earliest next accepting edge is E18, while done is high; start in the done cycle is accepted. Minimum issue interval is 18 cycles.
- Reset values: state IDLE, rnd 0, L/R/CD 0, busy 0, done 0, encryptmessage 64'h0.
- Reset asserted mid-operation aborts the block immediately:
  - done does not pulse.
  - encryptmessage is cleared to 0, not left at the prior ciphertext.
- Critical path: one f-function plus PC-2 and the rotate. The f-function is never chained across rounds within a cycle.

## Structure
- Shared package `des_pkg` holds:
  - NUM_ROUNDS = 16.
  - 16-entry SHIFT schedule constant.
  - FSM state enum (IDLE, ROUND, OUT).
  - Width constants: 64, 56, 48, 32.
- Sub-module `des_round` (combinational) computes one round:
  - Inputs: L, R, CD, shift amount.
  - Outputs: next L, next R, next CD.
  - Internally instantiates `pctwo` and `fencode`.
- Top level holds the FSM, rnd counter and state registers, plus `dataip`, `pcone` and `ipinverse` on the load and unload paths.

## Test plan
- Known answer: key 133457799BBCDFF1, message 0123456789ABCDEF, one start pulse → done exactly 17 cycles later with encryptmessage 85E813540F0AB405. busy is high for 17 cycles.
- Second known answer: key 0E329232EA6D0D73, message 8787878787878787 → 0000000000000000. All-zero key and message → 8CA64DE9C1B123A7.
- Round trip: 1000 random key/plaintext pairs, each ciphertext fed to `decrypt` with the same key → original plaintext returned.
- Start held high continuously with changing message/key:
  - Only the values on the accepting edges are used.
  - Blocks complete every 18 cycles, each with a single-cycle done.
  - Mid-flight start pulses have no effect.
- Asynchronous rst pulse at E8 of a block:
  - Outputs go to zero immediately.
  - No done for that block.
  - A fresh start after reset release produces the correct vector-1 result.
- Input hold: after the accepting edge, message/key are driven to random values every cycle → result still equals the ciphertext of the sampled values. encryptmessage is stable between done pulses.
